// File: rtl/cache_pkg.sv
// Shared cache-line geometry and the line responder state encoding,
// also used by the cache controller.
package cache_pkg;

  localparam int LINE_WORDS = 4;
  // Byte-offset bits inside one line of 32-bit words.
  localparam int LINE_OFF_W = $clog2(LINE_WORDS * 4);

  typedef enum logic [2:0] {
    IDLE,
    LAT_WAIT,
    RD_BURST,
    WR_DATA,
    WR_ACK
  } state_e;

endpackage

// File: rtl/line_mem_array.sv
// Line storage: one synchronous 32-bit write port and one registered read port.
// Contents are never reset.
module line_mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for cache line refills (read bursts) and writebacks,
// with a fixed access latency before the first response.
module line_mem_responder #(
  parameter int LINE_WORDS  = cache_pkg::LINE_WORDS,
  parameter int DEPTH_LINES = 256,
  parameter int LAT         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last
);

  import cache_pkg::*;

  localparam int LIW = $clog2(DEPTH_LINES);
  localparam int BW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [3:0]    LAT_M1    = 4'(LAT - 1);

  state_e         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [3:0]     lat_q, lat_d;
  logic [LIW-1:0] line_q, line_d;
  logic           we_q, we_d;

  logic           mem_we;
  logic [31:0]    mem_rdata;
  logic           unused_addr_bits;

  // Offset and bits above the line index only select a byte or alias lines.
  assign unused_addr_bits = ^{req_addr[31:LINE_OFF_W+LIW], req_addr[LINE_OFF_W-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      line_q  <= line_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    line_d    = line_q;
    we_d      = we_q;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_data  = '0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_d = req_addr[LINE_OFF_W +: LIW];
          we_d   = req_we;
          beat_d = '0;
          if (req_we) begin
            state_d = WR_DATA;
          end else begin
            state_d = LAT_WAIT;
            lat_d   = LAT_M1;
          end
        end
      end

      // Counter loaded with LAT-1 so the response shows up LAT edges later.
      LAT_WAIT: begin
        if (lat_q == '0) begin
          state_d = we_q ? WR_ACK : RD_BURST;
          beat_d  = '0;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      RD_BURST: begin
        rsp_valid = 1'b1;
        rsp_data  = mem_rdata;
        rsp_last  = (beat_q == LAST_BEAT);
        if (rsp_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      WR_DATA: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = LAT_WAIT;
            lat_d   = LAT_M1;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      WR_ACK: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Read address follows the next beat so the registered read data lines up
  // with the beat presented; during a stall the same word is simply re-read.
  line_mem_array #(
    .ADDR_W(LIW + BW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr({line_q, beat_q}),
    .wdata(wr_data),
    .raddr({line_q, beat_d}),
    .rdata(mem_rdata)
  );

endmodule
